// File: rtl/e_mdu_ctrl_pkg.sv
// Shared MDU operation codes, default latencies and state encoding for the E-stage
// multiply/divide controller.
package e_mdu_ctrl_pkg;

    typedef logic [3:0] mdu_op_t;

    localparam mdu_op_t MDU_none  = 4'd0;
    localparam mdu_op_t MDU_mult  = 4'd1;
    localparam mdu_op_t MDU_multu = 4'd2;
    localparam mdu_op_t MDU_div   = 4'd3;
    localparam mdu_op_t MDU_divu  = 4'd4;
    localparam mdu_op_t MDU_mfhi  = 4'd5;
    localparam mdu_op_t MDU_mflo  = 4'd6;
    localparam mdu_op_t MDU_mthi  = 4'd7;
    localparam mdu_op_t MDU_mtlo  = 4'd8;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // The controller state is carried directly by the busy flop.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic logic is_arith(input mdu_op_t op);
        return (op == MDU_mult) || (op == MDU_multu) ||
               (op == MDU_div)  || (op == MDU_divu);
    endfunction

    function automatic logic is_div(input mdu_op_t op);
        return (op == MDU_div) || (op == MDU_divu);
    endfunction

endpackage

// File: rtl/e_mdu_ctrl_if.sv
// E-stage request/response bundle between the pipeline and the MDU controller.
interface e_mdu_ctrl_if;
    import e_mdu_ctrl_pkg::*;

    logic        req_valid;
    mdu_op_t     MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] rdata;

    modport slave (
        input  req_valid, MDUOp, A, B,
        output start, busy, HI, LO, rdata
    );

    modport master (
        output req_valid, MDUOp, A, B,
        input  start, busy, HI, LO, rdata
    );

endinterface

// File: rtl/e_mdu_ctrl.sv
// Execute-stage multiply/divide controller owning HI/LO with fixed-latency sequencing.
// Optional exception flush input is enabled by defining MDU_FLUSH_EN.
module e_mdu_ctrl
    import e_mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic          clk,
    input  logic          reset,
`ifdef MDU_FLUSH_EN
    input  logic          flush,
`endif
    e_mdu_ctrl_if.slave   mdu
);

    logic [0:0]         state;
    logic [3:0]         counter;
    logic [31:0]        hi_q, lo_q;
    logic [31:0]        hi_p, lo_p;
    logic               pend_we;
    logic               flush_i;

    logic signed [31:0] a_s, b_s;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic signed [31:0] q_s, r_s;
    logic [31:0]        q_u, r_u;
    logic [31:0]        res_hi, res_lo;
    logic               res_we;

`ifdef MDU_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    assign a_s    = $signed(mdu.A);
    assign b_s    = $signed(mdu.B);
    assign prod_s = a_s * b_s;
    assign prod_u = {32'd0, mdu.A} * {32'd0, mdu.B};

    // Divisor zero and INT_MIN/-1 are steered away from the divider so the
    // result is well defined in every simulator and netlist.
    always_comb begin
        q_s = '0;
        r_s = '0;
        q_u = '0;
        r_u = '0;
        if (mdu.B != 32'd0) begin
            if (mdu.A == 32'h8000_0000 && mdu.B == 32'hFFFF_FFFF) begin
                q_s = $signed(32'h8000_0000);
                r_s = '0;
            end else begin
                q_s = a_s / b_s;
                r_s = a_s % b_s;
            end
            q_u = mdu.A / mdu.B;
            r_u = mdu.A % mdu.B;
        end
    end

    always_comb begin
        res_hi = hi_q;
        res_lo = lo_q;
        res_we = 1'b1;
        case (mdu.MDUOp)
            MDU_mult:  {res_hi, res_lo} = prod_s;
            MDU_multu: {res_hi, res_lo} = prod_u;
            MDU_div:   begin res_hi = r_s; res_lo = q_s; end
            MDU_divu:  begin res_hi = r_u; res_lo = q_u; end
            default:   res_we = 1'b0;
        endcase
        if (is_div(mdu.MDUOp) && mdu.B == 32'd0) res_we = 1'b0;
    end

    assign mdu.start = mdu.req_valid && is_arith(mdu.MDUOp) && (state == ST_IDLE);
    assign mdu.busy  = (state == ST_RUN);
    assign mdu.HI    = hi_q;
    assign mdu.LO    = lo_q;

    always_comb begin
        mdu.rdata = '0;
        case (mdu.MDUOp)
            MDU_mfhi: mdu.rdata = hi_q;
            MDU_mflo: mdu.rdata = lo_q;
            default:  mdu.rdata = '0;
        endcase
    end

    // Flush beats everything; a running op only counts down; moves to HI/LO
    // are honoured only while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            counter <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            hi_p    <= '0;
            lo_p    <= '0;
            pend_we <= 1'b0;
        end else if (flush_i) begin
            state   <= ST_IDLE;
            counter <= '0;
            pend_we <= 1'b0;
        end else if (state == ST_RUN) begin
            if (counter == 4'd1) begin
                state   <= ST_IDLE;
                counter <= '0;
                pend_we <= 1'b0;
                if (pend_we) begin
                    hi_q <= hi_p;
                    lo_q <= lo_p;
                end
            end else begin
                counter <= counter - 4'd1;
            end
        end else if (mdu.start) begin
            state   <= ST_RUN;
            counter <= is_div(mdu.MDUOp) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            hi_p    <= res_hi;
            lo_p    <= res_lo;
            pend_we <= res_we;
        end else if (mdu.req_valid && mdu.MDUOp == MDU_mthi) begin
            hi_q <= mdu.A;
        end else if (mdu.req_valid && mdu.MDUOp == MDU_mtlo) begin
            lo_q <= mdu.A;
        end
    end

endmodule
